sim_axi4_mem_model: RTL
=======================

Name: sim_axi4_mem_model

Overview:
- RTL AXI4 slave memory model attached directly to one mem_N channel of FPGATop in the metasimulation top.
- Replaces the host-side DPI memory for that channel: it consumes FPGATop's mem_N_* requests and produces the responses the channel expects.
- Fixed, programmable read latency, INCR bursts, one outstanding transaction per direction, byte-strobed writes.
- Gives deterministic DRAM-like timing for bridge regression without a host round-trip.

Parameters:
ADDR_BITS, 34, AXI address width; must equal MEM_ADDR_BITS.
DATA_BITS, 64, data width (power of two, >= 32); must equal MEM_DATA_BITS.
ID_BITS, 4, AXI ID width; must equal MEM_ID_BITS.
DEPTH_WORDS, 4096, backing array depth in DATA_BITS words (power of two).
READ_LATENCY, 8, cycles from AR handshake to first R valid (0..255).

Ports:
clock  in  1  sole clock
reset  in  1  synchronous, active-high
mem_ar_valid / mem_ar_ready  in / out  1  AR handshake
mem_ar_bits_addr  in  ADDR_BITS  read byte address
mem_ar_bits_id  in  ID_BITS  read ID
mem_ar_bits_size  in  3  log2 bytes per beat
mem_ar_bits_len  in  8  beats minus 1
mem_aw_valid / mem_aw_ready  in / out  1  AW handshake
mem_aw_bits_addr, _id, _size, _len  in  ADDR_BITS, ID_BITS, 3, 8  as AR
mem_w_valid / mem_w_ready  in / out  1  W handshake
mem_w_bits_data  in  DATA_BITS  write data
mem_w_bits_strb  in  DATA_BITS/8  byte enables
mem_w_bits_last  in  1  final write beat
mem_r_valid / mem_r_ready  out / in  1  R handshake
mem_r_bits_data  out  DATA_BITS  read data
mem_r_bits_id  out  ID_BITS  = latched AR id
mem_r_bits_resp  out  2  0 = OKAY, 2 = SLVERR
mem_r_bits_last  out  1  final read beat
mem_b_valid / mem_b_ready  out / in  1  B handshake
mem_b_bits_id  out  ID_BITS  = latched AW id
mem_b_bits_resp  out  2  0 = OKAY, 2 = SLVERR

Behaviour:
- Interface: one clock, clock; reset is synchronous and active-high.
- Reset: all *_valid = 0; ar_ready = 1; aw_ready = 1; w_ready = 0. r/b payloads = 0. Both FSMs go IDLE. The backing array is NOT cleared.
- Reset mid-burst: the transaction is dropped. No further R/B beats are issued. Partially written words keep the data already committed.
- Word index = addr >> log2(DATA_BITS/8).
  - Out of range: index >= DEPTH_WORDS.
  - Illegal size: size > log2(DATA_BITS/8).
  - Any beat that is out of range or illegal gets SLVERR. Such a beat reads 0 and is not written.
- Read FSM, states R_IDLE, R_WAIT, R_DATA:
  - R_IDLE: ar_ready = 1. On ar_valid, latch id/addr/size/len, beat count = 0, latency counter = READ_LATENCY.
    - Next state is R_WAIT, or R_DATA if READ_LATENCY = 0 (r_valid then rises the cycle after the AR handshake).
  - R_WAIT: decrement the counter each cycle. Enter R_DATA when it reaches 1. The first r_valid appears exactly READ_LATENCY cycles after the AR handshake cycle.
  - R_DATA: r_valid = 1. r_data/r_resp are captured from the array when the beat is presented and held stable while r_valid && !r_ready.
    - r_last = 1 on the beat where count == len.
    - On an r handshake: addr += 1 << size, count++. On the last handshake go to R_IDLE; ar_ready rises the next cycle.
  - r_ready low indefinitely: hold state, no data change.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: aw_ready = 1. On aw_valid, latch id/addr/size/len and go to W_DATA.
  - W_DATA: w_ready = 1.
    - Each w handshake writes the strb-selected bytes at the current word, then addr += 1 << size and count++.
    - W_DATA ends on the beat with w_last = 1, then goes to W_RESP.
    - If the beat count on w_last != len + 1, b_resp = SLVERR. The beats already written stay written.
  - W_RESP: b_valid = 1, holding id/resp until the b handshake, then W_IDLE.
  - W beats are never accepted before the AW handshake.
- Simultaneous AR and AW: both are accepted in the same cycle; the FSMs are independent.
- Same-cycle read and write of the same word: the write is committed at the clock edge. A read beat presented in that same cycle returns the old data; a beat presented later returns the new data.
- Address wrap: addr arithmetic is ADDR_BITS wide, modulo 2^ADDR_BITS. Beats that land out of range report SLVERR per beat.

Test Plan:
- Reset, READ_LATENCY = 8: AR addr 0x40, len 0, size 3, id 5 -> r_valid rises exactly 8 cycles after the handshake; r_id 5, r_last 1, r_resp 0, data = preloaded word 8.
- AW addr 0x100, len 3, size 3; four W beats 0xA0..0xA3, strb 0xFF, last on beat 4 -> b_resp 0. A following 4-beat read returns 0xA0..0xA3 with r_last only on beat 4.
- Strobe merge: word holds 0x1122334455667788; write 0xFFFFFFFFFFFFFFFF with strb 0x0F -> readback 0x11223344FFFFFFFF.
- Backpressure: hold r_ready = 0 for 10 cycles mid-burst -> r_data, r_valid and r_last stay constant, and no beat is skipped.
- Errors:
  - AR addr = DEPTH_WORDS*8 -> r_resp 2, data 0.
  - W burst with len 3 but w_last on beat 2 -> b_resp 2, and the 2 beats are written.
  - size 4 on 64-bit data -> SLVERR.
- Assert reset during a write burst after 2 of 4 beats, then issue a new AR/AW -> no stale B, fresh transactions complete normally, and the first 2 beats persist.

Source files
------------

// File: rtl/sim_axi4_mem_model.sv
// AXI4 slave memory model for one FPGATop mem channel: fixed read latency, INCR bursts,
// one outstanding transaction per direction, byte-strobed writes, per-beat SLVERR.
module sim_axi4_mem_model #(
  parameter int ADDR_BITS    = 34,
  parameter int DATA_BITS    = 64,
  parameter int ID_BITS      = 4,
  parameter int DEPTH_WORDS  = 4096,
  parameter int READ_LATENCY = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   mem_ar_valid,
  output logic                   mem_ar_ready,
  input  logic [ADDR_BITS-1:0]   mem_ar_bits_addr,
  input  logic [ID_BITS-1:0]     mem_ar_bits_id,
  input  logic [2:0]             mem_ar_bits_size,
  input  logic [7:0]             mem_ar_bits_len,
  input  logic                   mem_aw_valid,
  output logic                   mem_aw_ready,
  input  logic [ADDR_BITS-1:0]   mem_aw_bits_addr,
  input  logic [ID_BITS-1:0]     mem_aw_bits_id,
  input  logic [2:0]             mem_aw_bits_size,
  input  logic [7:0]             mem_aw_bits_len,
  input  logic                   mem_w_valid,
  output logic                   mem_w_ready,
  input  logic [DATA_BITS-1:0]   mem_w_bits_data,
  input  logic [DATA_BITS/8-1:0] mem_w_bits_strb,
  input  logic                   mem_w_bits_last,
  output logic                   mem_r_valid,
  input  logic                   mem_r_ready,
  output logic [DATA_BITS-1:0]   mem_r_bits_data,
  output logic [ID_BITS-1:0]     mem_r_bits_id,
  output logic [1:0]             mem_r_bits_resp,
  output logic                   mem_r_bits_last,
  output logic                   mem_b_valid,
  input  logic                   mem_b_ready,
  output logic [ID_BITS-1:0]     mem_b_bits_id,
  output logic [1:0]             mem_b_bits_resp
);
  localparam int STRB_BITS = DATA_BITS / 8;
  localparam int SHIFT     = $clog2(STRB_BITS);
  localparam int IDX_W     = $clog2(DEPTH_WORDS);

  typedef logic [ADDR_BITS-1:0] addr_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  function automatic logic beat_ok(input addr_t a, input logic [2:0] s);
    return (s <= 3'(SHIFT)) && (a[ADDR_BITS-1:SHIFT+IDX_W] == '0);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input addr_t a);
    return a[SHIFT +: IDX_W];
  endfunction

  function automatic addr_t next_addr(input addr_t a, input logic [2:0] s);
    return a + (addr_t'(1) << s);
  endfunction

  logic [DATA_BITS-1:0] mem [DEPTH_WORDS];

  r_state_t       r_state, r_state_nxt;
  addr_t          r_addr, ld_addr;
  logic [2:0]     r_size, ld_size;
  logic [7:0]     r_len, r_beat, r_cnt;
  logic           r_load, ld_last;
  logic [DATA_BITS-1:0] r_data;
  logic [ID_BITS-1:0]   r_id;
  logic [1:0]     r_resp;
  logic           r_last;

  assign mem_r_bits_data = r_data;
  assign mem_r_bits_id   = r_id;
  assign mem_r_bits_resp = r_resp;
  assign mem_r_bits_last = r_last;

  // Read control: r_load marks the cycle whose edge captures the next presented beat.
  always_comb begin
    r_state_nxt  = r_state;
    mem_ar_ready = 1'b0;
    mem_r_valid  = 1'b0;
    r_load       = 1'b0;
    ld_addr      = r_addr;
    ld_size      = r_size;
    ld_last      = (r_len == 8'd0);
    case (r_state)
      R_IDLE: begin
        mem_ar_ready = 1'b1;
        if (mem_ar_valid) begin
          ld_addr = mem_ar_bits_addr;
          ld_size = mem_ar_bits_size;
          ld_last = (mem_ar_bits_len == 8'd0);
          if (READ_LATENCY <= 1) begin
            r_state_nxt = R_DATA;
            r_load      = 1'b1;
          end else begin
            r_state_nxt = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (r_cnt == 8'd2) begin
          r_state_nxt = R_DATA;
          r_load      = 1'b1;
        end
      end
      R_DATA: begin
        mem_r_valid = 1'b1;
        if (mem_r_ready) begin
          if (r_last) begin
            r_state_nxt = R_IDLE;
          end else begin
            r_load  = 1'b1;
            ld_addr = next_addr(r_addr, r_size);
            ld_last = (r_beat + 8'd1 == r_len);
          end
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= R_IDLE;
      r_data  <= '0;
      r_id    <= '0;
      r_resp  <= 2'b00;
      r_last  <= 1'b0;
    end else begin
      r_state <= r_state_nxt;
      if (mem_ar_valid && mem_ar_ready) begin
        r_id   <= mem_ar_bits_id;
        r_len  <= mem_ar_bits_len;
        r_size <= mem_ar_bits_size;
        r_addr <= mem_ar_bits_addr;
        r_cnt  <= 8'(READ_LATENCY);
        r_beat <= 8'd0;
      end
      if (r_state == R_WAIT)
        r_cnt <= r_cnt - 8'd1;
      if (mem_r_valid && mem_r_ready)
        r_beat <= r_beat + 8'd1;
      if (r_load) begin
        r_addr <= ld_addr;
        r_last <= ld_last;
        if (beat_ok(ld_addr, ld_size)) begin
          r_data <= mem[word_idx(ld_addr)];
          r_resp <= 2'b00;
        end else begin
          r_data <= '0;
          r_resp <= 2'b10;
        end
      end
    end
  end

  w_state_t       w_state, w_state_nxt;
  addr_t          w_addr;
  logic [2:0]     w_size;
  logic [7:0]     w_len;
  logic [8:0]     w_cnt;
  logic           w_err, w_fire, w_ok;
  logic [ID_BITS-1:0] w_id, b_id;
  logic [1:0]     b_resp;

  assign mem_b_bits_id   = b_id;
  assign mem_b_bits_resp = b_resp;
  assign w_fire = mem_w_valid && mem_w_ready;
  assign w_ok   = beat_ok(w_addr, w_size);

  // Write control: W beats are only accepted after the AW handshake.
  always_comb begin
    w_state_nxt  = w_state;
    mem_aw_ready = (w_state == W_IDLE);
    mem_w_ready  = (w_state == W_DATA);
    mem_b_valid  = (w_state == W_RESP);
    case (w_state)
      W_IDLE:  if (mem_aw_valid) w_state_nxt = W_DATA;
      W_DATA:  if (mem_w_valid && mem_w_bits_last) w_state_nxt = W_RESP;
      W_RESP:  if (mem_b_ready) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      w_state <= W_IDLE;
      b_id    <= '0;
      b_resp  <= 2'b00;
    end else begin
      w_state <= w_state_nxt;
      if (mem_aw_valid && mem_aw_ready) begin
        w_id   <= mem_aw_bits_id;
        w_addr <= mem_aw_bits_addr;
        w_size <= mem_aw_bits_size;
        w_len  <= mem_aw_bits_len;
        w_cnt  <= 9'd0;
        w_err  <= 1'b0;
      end
      if (w_fire) begin
        w_addr <= next_addr(w_addr, w_size);
        w_cnt  <= w_cnt + 9'd1;
        w_err  <= w_err | ~w_ok;
        if (mem_w_bits_last) begin
          b_id   <= w_id;
          b_resp <= (w_err || !w_ok || (w_cnt != {1'b0, w_len})) ? 2'b10 : 2'b00;
        end
      end
    end
  end

  // Array commit; a read captured at this same edge still sees the old word.
  always_ff @(posedge clock) begin
    if (!reset && w_fire && w_ok) begin
      for (int i = 0; i < STRB_BITS; i++)
        if (mem_w_bits_strb[i])
          mem[word_idx(w_addr)][8*i +: 8] <= mem_w_bits_data[8*i +: 8];
    end
  end
endmodule
